cx4_mem_arbiter: RTL and testbench

Time-multiplexes the single external ROM/SRAM port among three requesters: the SNES bus (after address mapping), the Cx4 core's program/data fetch, and the MCU. It sits between the mapped SNES address path and the external memory pins in the Cx4 build. It guarantees every SNES access finishes within a bounded window, and it keeps the MCU from starving behind continuous Cx4 traffic.

---
 rtl/cx4_mem_arbiter_pkg.sv | 27 ++
 rtl/cx4_mem_arbiter_if.sv | 52 +++++
 rtl/cx4_mem_arbiter_mem_strobe_timer.sv | 73 +++++++
 rtl/cx4_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cx4_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cx4_mem_arbiter_pkg.sv
// Shared definitions for the Cx4 external memory arbiter.
// Holds the requester ids, the arbiter state encoding, the legal range of the
// per-access cycle count and the width of the small internal counters.
package cx4_mem_arbiter_pkg;

  // Requester ids; SRC_NONE means no grant was made.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SNES = 2'd1,
    SRC_CX4  = 2'd2,
    SRC_MCU  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Legal clocks per memory access.
  localparam int CYCLES_MIN = 3;
  localparam int CYCLES_MAX = 15;

  // Width of the cycle and starvation counters (both top out at 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/cx4_mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the external
// memory pins.
//   SNES_*  : one-cycle request pulse with write qualifier, addr, data; RDY pulse
//   CX4_*   : level read request with addr; RDY pulse when RD_DATA is valid
//   MCU_*   : level request with write qualifier, addr, data; RDY pulse
//   RD_DATA : last read data, shared by all requesters
//   RAM_*   : external memory address, write data, data-bus enable, strobes;
//             RAM_DIN is the data returned by the memory
// Handshake: SNES_REQ is a single-cycle pulse that is remembered by the
// arbiter; CX4_REQ/MCU_REQ are levels the requester holds until its RDY. Every
// RDY is a single-cycle pulse marking completion of exactly one access.
// master = requesters plus memory model, slave = arbiter.
interface cx4_mem_arbiter_if;
  logic        SNES_REQ;
  logic        SNES_WE;
  logic [23:0] SNES_ADDR;
  logic [7:0]  SNES_WDATA;
  logic        SNES_RDY;
  logic        CX4_REQ;
  logic [23:0] CX4_ADDR;
  logic        CX4_RDY;
  logic        MCU_REQ;
  logic        MCU_WE;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_WDATA;
  logic        MCU_RDY;
  logic [7:0]  RD_DATA;
  logic [23:0] RAM_ADDR;
  logic [7:0]  RAM_WDATA;
  logic [7:0]  RAM_DIN;
  logic        RAM_DATA_OE;
  logic        RAM_RD;
  logic        RAM_WE;

  modport master (
    output SNES_REQ, SNES_WE, SNES_ADDR, SNES_WDATA,
    output CX4_REQ, CX4_ADDR,
    output MCU_REQ, MCU_WE, MCU_ADDR, MCU_WDATA,
    output RAM_DIN,
    input  SNES_RDY, CX4_RDY, MCU_RDY, RD_DATA,
    input  RAM_ADDR, RAM_WDATA, RAM_DATA_OE, RAM_RD, RAM_WE
  );

  modport slave (
    input  SNES_REQ, SNES_WE, SNES_ADDR, SNES_WDATA,
    input  CX4_REQ, CX4_ADDR,
    input  MCU_REQ, MCU_WE, MCU_ADDR, MCU_WDATA,
    input  RAM_DIN,
    output SNES_RDY, CX4_RDY, MCU_RDY, RD_DATA,
    output RAM_ADDR, RAM_WDATA, RAM_DATA_OE, RAM_RD, RAM_WE
  );
endinterface

// File: rtl/cx4_mem_arbiter_mem_strobe_timer.sv
// Strobe window generator for one external memory access.
//   clk, rst    : clock, synchronous active-high reset
//   start, we   : begin a window of CYCLES clocks; we selects write strobes
//   ram_rd      : high for the whole window of a read
//   ram_data_oe : high for the whole window of a write
//   ram_we      : high for every write window cycle except the first and last
//   last        : high in the final window cycle
// Strobes are computed from the next counter value so they leave flops.
module mem_strobe_timer
  import cx4_mem_arbiter_pkg::*;
#(
  parameter int CYCLES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic we,
  output logic ram_rd,
  output logic ram_we,
  output logic ram_data_oe,
  output logic last
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             we_q, we_d;
  logic             rd_q, rd_d;
  logic             wstb_q, wstb_d;
  logic             oe_q, oe_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    we_d     = we_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CNT_LOAD;
      we_d     = we;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
    rd_d   = active_d & ~we_d;
    oe_d   = active_d & we_d;
    // First window cycle holds CNT_LOAD, last holds 0: both give address
    // setup/hold around the write strobe.
    wstb_d = active_d & we_d & (cnt_d != CNT_LOAD) & (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wstb_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wstb_q   <= wstb_d;
      oe_q     <= oe_d;
    end
  end

  assign ram_rd      = rd_q;
  assign ram_we      = wstb_q;
  assign ram_data_oe = oe_q;
  assign last        = active_q & (cnt_q == '0);
endmodule

// File: rtl/cx4_mem_arbiter.sv
// Time-multiplexes the external ROM/SRAM port between the SNES bus, the Cx4
// core and the MCU.
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : requester handshakes and memory pins (slave side)
//   dbg_state : current arbiter state
// Priority in IDLE: SNES (pending or arriving) > starved MCU > Cx4 > MCU.
// One access takes CYCLES strobe clocks plus a DONE clock plus the IDLE clock.
module cx4_mem_arbiter
  import cx4_mem_arbiter_pkg::*;
#(
  parameter int CYCLES     = 6,
  parameter int MCU_STARVE = 8
) (
  input  logic              CLK,
  input  logic              RST,
  cx4_mem_arbiter_if.slave  bus,
  output state_e            dbg_state
);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MCU_STARVE);

  state_e           state_q, state_d;
  src_e             src_q, src_d, grant_src;
  logic             we_q, we_d;
  logic [23:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             snes_pend_q, snes_pend_d;
  logic             snes_we_q, snes_we_d;
  logic [23:0]      snes_addr_q, snes_addr_d;
  logic [7:0]       snes_wdata_q, snes_wdata_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             snes_any, snes_sel_we, mcu_starved;
  logic [23:0]      snes_sel_addr;
  logic [7:0]       snes_sel_wdata;
  logic             tmr_last;
  logic             snes_rdy, cx4_rdy, mcu_rdy;

  // A pulse in the grant cycle is served directly so it beats a Cx4 request
  // rising in the same cycle; the newest pulse always wins.
  assign snes_any       = bus.SNES_REQ | snes_pend_q;
  assign snes_sel_we    = bus.SNES_REQ ? bus.SNES_WE    : snes_we_q;
  assign snes_sel_addr  = bus.SNES_REQ ? bus.SNES_ADDR  : snes_addr_q;
  assign snes_sel_wdata = bus.SNES_REQ ? bus.SNES_WDATA : snes_wdata_q;
  assign mcu_starved    = bus.MCU_REQ & (starve_q == STARVE_MAX);

  always_comb begin
    grant_src = SRC_NONE;
    if (state_q == ST_IDLE) begin
      if (snes_any)         grant_src = SRC_SNES;
      else if (mcu_starved) grant_src = SRC_MCU;
      else if (bus.CX4_REQ) grant_src = SRC_CX4;
      else if (bus.MCU_REQ) grant_src = SRC_MCU;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_src != SRC_NONE) state_d = ST_ACCESS;
      ST_ACCESS: if (tmr_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture registers, pending flag and starvation counter.
  always_comb begin
    src_d        = src_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    snes_we_d    = snes_we_q;
    snes_addr_d  = snes_addr_q;
    snes_wdata_d = snes_wdata_q;
    snes_pend_d  = snes_pend_q;
    starve_d     = starve_q;

    if (bus.SNES_REQ) begin
      snes_pend_d  = 1'b1;
      snes_we_d    = bus.SNES_WE;
      snes_addr_d  = bus.SNES_ADDR;
      snes_wdata_d = bus.SNES_WDATA;
    end

    unique case (grant_src)
      SRC_SNES: begin
        src_d   = SRC_SNES;
        we_d    = snes_sel_we;
        addr_d  = snes_sel_addr;
        wdata_d = snes_sel_wdata;
        // Cleared at grant rather than completion so a pulse arriving
        // during this access is kept as a fresh request.
        snes_pend_d = 1'b0;
      end
      SRC_CX4: begin
        src_d   = SRC_CX4;
        we_d    = 1'b0;
        addr_d  = bus.CX4_ADDR;
        wdata_d = 8'h00;
      end
      SRC_MCU: begin
        src_d   = SRC_MCU;
        we_d    = bus.MCU_WE;
        addr_d  = bus.MCU_ADDR;
        wdata_d = bus.MCU_WDATA;
      end
      default: ;
    endcase

    if (state_q == ST_ACCESS && tmr_last && !we_q) rd_data_d = bus.RAM_DIN;

    if (!bus.MCU_REQ || grant_src == SRC_MCU)
      starve_d = '0;
    else if (grant_src == SRC_CX4 && starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      snes_pend_q  <= 1'b0;
      snes_we_q    <= 1'b0;
      snes_addr_q  <= '0;
      snes_wdata_q <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      snes_pend_q  <= snes_pend_d;
      snes_we_q    <= snes_we_d;
      snes_addr_q  <= snes_addr_d;
      snes_wdata_q <= snes_wdata_d;
      starve_q     <= starve_d;
    end
  end

  // Output decode: RDY of the granted source during DONE.
  always_comb begin
    snes_rdy = 1'b0;
    cx4_rdy  = 1'b0;
    mcu_rdy  = 1'b0;
    if (state_q == ST_DONE) begin
      snes_rdy = (src_q == SRC_SNES);
      cx4_rdy  = (src_q == SRC_CX4);
      mcu_rdy  = (src_q == SRC_MCU);
    end
  end

  mem_strobe_timer #(.CYCLES(CYCLES)) u_timer (
    .clk         (CLK),
    .rst         (RST),
    .start       (grant_src != SRC_NONE),
    .we          (we_d),
    .ram_rd      (bus.RAM_RD),
    .ram_we      (bus.RAM_WE),
    .ram_data_oe (bus.RAM_DATA_OE),
    .last        (tmr_last)
  );

  assign bus.SNES_RDY  = snes_rdy;
  assign bus.CX4_RDY   = cx4_rdy;
  assign bus.MCU_RDY   = mcu_rdy;
  assign bus.RD_DATA   = rd_data_q;
  assign bus.RAM_ADDR  = addr_q;
  assign bus.RAM_WDATA = wdata_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_cx4_mem_arbiter.sv
// Directed bench for cx4_mem_arbiter: expected accesses are queued when a
// request is driven and checked by a monitor when the matching RDY appears.
module tb_cx4_mem_arbiter;
  import cx4_mem_arbiter_pkg::*;

  localparam int C      = 6;
  localparam int STARVE = 8;
  localparam int EW     = 35;  // {src[1:0], we, addr[23:0], wdata[7:0]}

  logic   CLK = 1'b0;
  logic   RST;
  state_e dbg_state;

  cx4_mem_arbiter_if bus();

  cx4_mem_arbiter #(.CYCLES(C), .MCU_STARVE(STARVE)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory model: data depends only on address.
  function automatic logic [7:0] mem_model(logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC2;
  endfunction
  assign bus.RAM_DIN = mem_model(bus.RAM_ADDR);

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(src_e s, logic we, logic [23:0] a, logic [7:0] d);
    return {s, we, a, d};
  endfunction

  function automatic logic [2:0] onehot(logic [1:0] s);
    case (s)
      SRC_SNES: return 3'b100;
      SRC_CX4:  return 3'b010;
      SRC_MCU:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  int            start_log[$];
  logic [EW-1:0] mon_e;
  logic [7:0]    exp_rd = 8'h00;
  int            done_cnt = 0;
  int            snes_rdy_cyc = 0;
  int            win_len = 0, we_len = 0, start_cyc = 0;
  logic          we_first_bad = 0, last_we = 0, addr_moved = 0, win_we = 0;
  logic [23:0]   win_addr = '0;
  logic [7:0]    win_wdata = '0;

  always @(negedge CLK) begin
    if (RST) begin
      win_len = 0; we_len = 0; we_first_bad = 0; last_we = 0; addr_moved = 0;
    end else begin
      if (bus.RAM_RD || bus.RAM_DATA_OE) begin
        if (win_len == 0) begin
          win_addr  = bus.RAM_ADDR;
          win_we    = bus.RAM_DATA_OE;
          win_wdata = bus.RAM_WDATA;
          start_cyc = cyc;
          if (bus.RAM_WE) we_first_bad = 1;
        end
        if (bus.RAM_ADDR !== win_addr) addr_moved = 1;
        if (bus.RAM_WE) we_len++;
        last_we = bus.RAM_WE;
        win_len++;
      end
      if (bus.SNES_RDY || bus.CX4_RDY || bus.MCU_RDY) begin
        if (exp_q.size() == 0) begin
          check("rdy_unexpected", 32'(done_cnt), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdy_src", 32'({bus.SNES_RDY, bus.CX4_RDY, bus.MCU_RDY}), 32'(onehot(mon_e[34:33])));
          check("win_addr", 32'(win_addr), 32'(mon_e[31:8]));
          check("addr_stable", 32'(addr_moved), 0);
          check("win_we", 32'(win_we), 32'(mon_e[32]));
          check("win_len", win_len, C);
          check("we_len", we_len, mon_e[32] ? C - 2 : 0);
          if (mon_e[32]) begin
            check("we_setup_hold", 32'({we_first_bad, last_we}), 0);
            check("wdata", 32'(win_wdata), 32'(mon_e[7:0]));
          end else begin
            exp_rd = mem_model(mon_e[31:8]);
          end
          check("rd_data", 32'(bus.RD_DATA), 32'(exp_rd));
          check("strobes_off", 32'({bus.RAM_RD, bus.RAM_WE, bus.RAM_DATA_OE}), 0);
          start_log.push_back(start_cyc);
        end
        if (bus.SNES_RDY) snes_rdy_cyc = cyc;
        done_cnt++;
        win_len = 0; we_len = 0; we_first_bad = 0; last_we = 0; addr_moved = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int pulse_cyc = 0;

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_done(int target, int budget);
    while (done_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    check("wait_done", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_strobe();
    int budget = 40;
    while (!(bus.RAM_RD || bus.RAM_DATA_OE) && budget > 0) begin
      step();
      budget--;
    end
    check("wait_strobe", 32'(bus.RAM_RD || bus.RAM_DATA_OE), 1);
  endtask

  task automatic snes_pulse(logic we, logic [23:0] a, logic [7:0] d);
    exp_q.push_back(pack(SRC_SNES, we, a, d));
    bus.SNES_REQ   = 1'b1;
    bus.SNES_WE    = we;
    bus.SNES_ADDR  = a;
    bus.SNES_WDATA = d;
    pulse_cyc      = cyc;
    step();
    bus.SNES_REQ   = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ram_addr"}, 32'(bus.RAM_ADDR), 0);
    check({tag, "_ram_wdata"}, 32'(bus.RAM_WDATA), 0);
    check({tag, "_rd_data"}, 32'(bus.RD_DATA), 0);
    check({tag, "_strobes"}, 32'({bus.RAM_RD, bus.RAM_WE, bus.RAM_DATA_OE}), 0);
    check({tag, "_rdys"}, 32'({bus.SNES_RDY, bus.CX4_RDY, bus.MCU_RDY}), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int base;

  initial begin
    RST = 1'b1;
    bus.SNES_REQ = 0; bus.SNES_WE = 0; bus.SNES_ADDR = '0; bus.SNES_WDATA = '0;
    bus.CX4_REQ = 0; bus.CX4_ADDR = '0;
    bus.MCU_REQ = 0; bus.MCU_WE = 0; bus.MCU_ADDR = '0; bus.MCU_WDATA = '0;
    repeat (3) step();
    check_all_zero("reset");
    RST = 1'b0;
    step();

    // 1: SNES read, RD_DATA 0xA5, RDY C+1 cycles after the pulse cycle
    snes_pulse(1'b0, 24'h012345, 8'h00);
    wait_done(1, 40);
    check("t1_rd_data", 32'(bus.RD_DATA), 32'h0000_00A5);
    check("t1_latency", snes_rdy_cyc - pulse_cyc, C + 1);

    // 2: MCU write 0x5A to 0xE00010
    exp_q.push_back(pack(SRC_MCU, 1'b1, 24'hE00010, 8'h5A));
    bus.MCU_REQ = 1; bus.MCU_WE = 1; bus.MCU_ADDR = 24'hE00010; bus.MCU_WDATA = 8'h5A;
    wait_done(2, 40);
    bus.MCU_REQ = 0;
    check("t2_ram_wdata", 32'(bus.RAM_WDATA), 32'h0000_005A);
    repeat (3) step();
    check("t2_idle", 32'(dbg_state), 32'(ST_IDLE));

    // 3: SNES pulse in the second cycle of a Cx4 read waits for it
    exp_q.push_back(pack(SRC_CX4, 1'b0, 24'h000100, 8'h00));
    bus.CX4_REQ = 1; bus.CX4_ADDR = 24'h000100;
    wait_strobe();
    step();
    snes_pulse(1'b0, 24'h123456, 8'h00);
    wait_done(3, 40);
    bus.CX4_REQ = 0;
    wait_done(4, 40);
    lat = snes_rdy_cyc - pulse_cyc;
    check("t3_lat_bound", 32'(lat <= 2 * (C + 2)), 1);
    // Remaining C-1 Cx4 cycles, DONE, IDLE, then its own C+1.
    check("t3_latency", lat, 2 * C + 1);

    // 6: SNES and Cx4 in the same IDLE cycle -> SNES first, Cx4 C+2 later
    exp_q.push_back(pack(SRC_SNES, 1'b0, 24'h00F00D, 8'h00));
    exp_q.push_back(pack(SRC_CX4, 1'b0, 24'h000400, 8'h00));
    bus.CX4_REQ = 1; bus.CX4_ADDR = 24'h000400;
    bus.SNES_REQ = 1; bus.SNES_WE = 0; bus.SNES_ADDR = 24'h00F00D;
    step();
    bus.SNES_REQ = 0;
    wait_done(5, 40);
    wait_done(6, 40);
    bus.CX4_REQ = 0;
    check("t6_spacing", start_log[start_log.size()-1] - start_log[start_log.size()-2], C + 2);

    // 7: MCU drops REQ mid-access and still completes
    exp_q.push_back(pack(SRC_MCU, 1'b0, 24'h000777, 8'h00));
    bus.MCU_REQ = 1; bus.MCU_WE = 0; bus.MCU_ADDR = 24'h000777;
    wait_strobe();
    step();
    bus.MCU_REQ = 0;
    wait_done(7, 40);

    // 4: continuous Cx4 + MCU -> 8 Cx4 grants then 1 MCU, twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < STARVE; k++)
        exp_q.push_back(pack(SRC_CX4, 1'b0, 24'h000200, 8'h00));
      exp_q.push_back(pack(SRC_MCU, 1'b0, 24'h000300, 8'h00));
    end
    bus.CX4_REQ = 1; bus.CX4_ADDR = 24'h000200;
    bus.MCU_REQ = 1; bus.MCU_WE = 0; bus.MCU_ADDR = 24'h000300;
    wait_done(7 + 2 * (STARVE + 1), 400);
    bus.CX4_REQ = 0; bus.MCU_REQ = 0;
    repeat (12) step();
    check("t4_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset on the third cycle of a write
    base = done_cnt;
    bus.MCU_REQ = 1; bus.MCU_WE = 1; bus.MCU_ADDR = 24'h00ABCD; bus.MCU_WDATA = 8'h3C;
    wait_strobe();
    step();
    step();
    check("t5_we_mid", 32'({bus.RAM_WE, bus.RAM_DATA_OE}), 32'h3);
    RST = 1'b1;
    bus.MCU_REQ = 0;
    exp_rd = 8'h00;
    step();
    check_all_zero("t5_reset");
    RST = 1'b0;
    repeat (10) step();
    check("t5_no_rdy", done_cnt, base);
    snes_pulse(1'b0, 24'h012345, 8'h00);
    wait_done(base + 1, 40);
    check("t5_after_rst_latency", snes_rdy_cyc - pulse_cyc, C + 1);
    check("t5_after_rst_data", 32'(bus.RD_DATA), 32'h0000_00A5);

    repeat (4) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
